// File: rtl/mem_arb_2to1_4b.sv
// Two-requester arbiter onto one memory port, with in-order response return via an ID FIFO.
// Build option MEM_ARB_FIXED_PRIO_EN: requester 0 always wins unlocked ties (default: round-robin).
module mem_arb_2to1_4b #(
  parameter int unsigned p_max_inflight = 4,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  // mem_req_4B_t: type(3) opaque addr len(2) data; mem_resp_4B_t: type(3) opaque test(2) len(2) data
  localparam int unsigned c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + 2 + p_data_nbits,
  localparam int unsigned c_resp_nbits = 3 + p_opaque_nbits + 2 + 2 + p_data_nbits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_req_nbits-1:0]  req0_msg,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_req_nbits-1:0]  req1_msg,
  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [c_resp_nbits-1:0] resp0_msg,
  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [c_resp_nbits-1:0] resp1_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [c_req_nbits-1:0]  memreq_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [c_resp_nbits-1:0] memresp_msg
);

  localparam int unsigned c_ptr_nbits = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam int unsigned c_cnt_nbits = c_ptr_nbits + 1;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_lock_gnt;
  logic                   r_last_grant;
  logic                   r_ids [p_max_inflight];
  logic [c_ptr_nbits-1:0] r_wr_ptr;
  logic [c_ptr_nbits-1:0] r_rd_ptr;
  logic [c_cnt_nbits-1:0] r_count;

  logic w_id_full;
  logic w_id_empty;
  logic w_head;
  logic w_tie_pick;
  logic w_grant;
  logic w_memreq_fire;
  logic w_memresp_fire;

  // Fullness uses the pre-pop count: a same-cycle pop never frees a push slot.
  assign w_id_full  = (r_count == c_cnt_nbits'(p_max_inflight));
  assign w_id_empty = (r_count == '0);
  assign w_head     = r_ids[r_rd_ptr];

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_tie_pick = 1'b0;
`else
  assign w_tie_pick = ~r_last_grant;
`endif

  assign memreq_val     = (req0_val | req1_val) & ~w_id_full & ~reset;
  assign memreq_msg     = w_grant ? req1_msg : req0_msg;
  assign req0_rdy       = ~w_grant & memreq_rdy & ~w_id_full & ~reset;
  assign req1_rdy       =  w_grant & memreq_rdy & ~w_id_full & ~reset;
  assign w_memreq_fire  = memreq_val & memreq_rdy;

  assign resp0_val      = memresp_val & ~w_id_empty & ~w_head & ~reset;
  assign resp1_val      = memresp_val & ~w_id_empty &  w_head & ~reset;
  assign resp0_msg      = memresp_msg;
  assign resp1_msg      = memresp_msg;
  assign memresp_rdy    = ~w_id_empty & (w_head ? resp1_rdy : resp0_rdy) & ~reset;
  assign w_memresp_fire = memresp_val & memresp_rdy;

  // Lock FSM: a stalled request keeps its grant until it fires.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = w_tie_pick;
    if (r_state == ST_LOCKED)       w_grant = r_lock_gnt;
    else if (req0_val && !req1_val) w_grant = 1'b0;
    else if (req1_val && !req0_val) w_grant = 1'b1;
    unique case (r_state)
      ST_OPEN:   if (memreq_val && !memreq_rdy) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_memreq_fire)             w_state_nxt = ST_OPEN;
      default:                                  w_state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_OPEN;
      r_lock_gnt   <= 1'b0;
      r_last_grant <= 1'b1;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_OPEN) r_lock_gnt <= w_grant;
      if (w_memreq_fire) begin
        r_last_grant <= w_grant;
        r_wr_ptr     <= r_wr_ptr + c_ptr_nbits'(1);
      end
      if (w_memresp_fire) r_rd_ptr <= r_rd_ptr + c_ptr_nbits'(1);
      r_count <= r_count + c_cnt_nbits'(w_memreq_fire) - c_cnt_nbits'(w_memresp_fire);
    end
  end

  // ID storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_memreq_fire) r_ids[r_wr_ptr] <= w_grant;
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is held (memresp_rdy stays low) and flagged here.
  a_resp_when_empty: assert property (@(posedge clk) disable iff (reset) !(memresp_val && w_id_empty));
`endif

endmodule

// File: tb/tb_mem_arb_2to1_4b.sv
// Randomized + directed bench for mem_arb_2to1_4b against a queue-based reference model.
module tb_mem_arb_2to1_4b;

  localparam int unsigned MAXI = 4;
  localparam int unsigned RQW  = 77;
  localparam int unsigned RSW  = 47;
  localparam int unsigned OVW  = 3 + RQW + 2 + 2 * RSW + 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_val, req0_rdy, req1_val, req1_rdy;
  logic [RQW-1:0] req0_msg, req1_msg, memreq_msg;
  logic           resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [RSW-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic           memreq_val, memreq_rdy, memresp_val, memresp_rdy;

  int checks = 0;
  int errors = 0;

  // Reference model state: last winner, lock, and the queue of outstanding requester IDs.
  int m_last;
  bit m_locked;
  int m_lock_idx;
  int m_q[$];

  mem_arb_2to1_4b #(.p_max_inflight(MAXI)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    m_last = 1; m_locked = 0; m_lock_idx = 0; m_q.delete();
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock_idx;
    if (req0_val && !req1_val) return 0;
    if (req1_val && !req0_val) return 1;
    return FIXED ? 0 : 1 - m_last;
  endfunction

  function automatic logic [OVW-1:0] m_out();
    int   g     = m_grant();
    logic full  = (m_q.size() == MAXI);
    logic empty = (m_q.size() == 0);
    int   head  = empty ? 0 : m_q[0];
    logic live  = !reset;
    logic mval  = (req0_val || req1_val) && !full && live;
    logic r0    = (g == 0) && memreq_rdy && !full && live;
    logic r1    = (g == 1) && memreq_rdy && !full && live;
    logic v0    = memresp_val && !empty && head == 0 && live;
    logic v1    = memresp_val && !empty && head == 1 && live;
    logic mrr   = !empty && (head == 1 ? resp1_rdy : resp0_rdy) && live;
    return {r0, r1, mval, (g == 1) ? req1_msg : req0_msg, v0, v1, memresp_msg, memresp_msg, mrr};
  endfunction

  function automatic logic [OVW-1:0] dut_out();
    return {req0_rdy, req1_rdy, memreq_val, memreq_msg, resp0_val, resp1_val,
            resp0_msg, resp1_msg, memresp_rdy};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void m_tick();
    int   g;
    logic full, mval, pop;
    if (reset) begin m_clear(); return; end
    g    = m_grant();
    full = (m_q.size() == MAXI);
    mval = (req0_val || req1_val) && !full;
    pop  = memresp_val && m_q.size() > 0 && (m_q[0] == 1 ? resp1_rdy : resp0_rdy);
    if (pop) void'(m_q.pop_front());
    if (mval && memreq_rdy) begin
      m_q.push_back(g); m_last = g; m_locked = 0;
    end else if (mval) begin
      m_lock_idx = g; m_locked = 1;
    end
  endfunction

  task automatic idle_inputs();
    req0_val = 0; req1_val = 0; memreq_rdy = 0; memresp_val = 0;
    resp0_rdy = 0; resp1_rdy = 0;
    req0_msg = RQW'({$urandom(), $urandom(), $urandom()});
    req1_msg = RQW'({$urandom(), $urandom(), $urandom()});
    memresp_msg = RSW'({$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; m_clear();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; m_clear();
    for (int i = 0; i < 3; i++) begin
      req0_val = 1; req1_val = 1; memreq_rdy = 1; memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out()) begin
        $display("FAIL reset_vec got=%h exp=%h", dut_out(), m_out()); errors++;
      end
      checks++;
      if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
        $display("FAIL reset_forced got=%b exp=000000",
                 {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy}); errors++;
      end
      m_tick();
      @(posedge clk); #1;
    end
    reset = 0; idle_inputs();
  endtask

  task automatic test_round_robin();
    int exp_g[6];
    int obs;
    for (int i = 0; i < 6; i++) exp_g[i] = FIXED ? 0 : (i % 2);
    do_reset();
    req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      memresp_val = (m_q.size() > 0);
      req0_msg = RQW'({$urandom(), $urandom(), $urandom()});
      req1_msg = RQW'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out()) begin
        $display("FAIL rr_vec[%0d] got=%h exp=%h", i, dut_out(), m_out()); errors++;
      end
      obs = (memreq_val && req1_rdy) ? 1 : (memreq_val && req0_rdy) ? 0 : -1;
      checks++;
      if (obs !== exp_g[i]) begin
        $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, obs, exp_g[i]); errors++;
      end
      m_tick();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [RQW-1:0] m1;
    do_reset();
    m1 = RQW'({$urandom(), $urandom(), $urandom()});
    for (int c = 1; c <= 5; c++) begin
      req1_val = 1; req1_msg = m1;
      req0_val = (c >= 2);
      memreq_rdy = (c >= 4);
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out()) begin
        $display("FAIL lock_vec[%0d] got=%h exp=%h", c, dut_out(), m_out()); errors++;
      end
      if (c <= 4) begin
        checks++;
        if (memreq_msg !== m1 || memreq_val !== 1'b1) begin
          $display("FAIL lock_msg[%0d] got=%h exp=%h", c, memreq_msg, m1); errors++;
        end
      end
      if (c >= 4) begin
        checks++;
        if ({req0_rdy, req1_rdy} !== ((c == 4) ? 2'b01 : 2'b10)) begin
          $display("FAIL lock_fire[%0d] got=%b exp=%b", c, {req0_rdy, req1_rdy},
                   (c == 4) ? 2'b01 : 2'b10); errors++;
        end
      end
      m_tick();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic exp_mval[7] = '{1, 1, 1, 1, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req0_val = 1; memreq_rdy = 1; resp0_rdy = 1;
      memresp_val = (c == 5);
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out()) begin
        $display("FAIL full_vec[%0d] got=%h exp=%h", c, dut_out(), m_out()); errors++;
      end
      checks++;
      if (memreq_val !== exp_mval[c] || req0_rdy !== exp_mval[c]) begin
        $display("FAIL full_mval[%0d] got=%b/%b exp=%b", c, memreq_val, req0_rdy, exp_mval[c]); errors++;
      end
      if (c == 5) begin
        checks++;
        if ({resp0_val, memresp_rdy} !== 2'b11) begin
          $display("FAIL full_pop got=%b exp=11", {resp0_val, memresp_rdy}); errors++;
        end
      end
      m_tick();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_interleave();
    int   ids[4]   = '{0, 1, 1, 0};
    logic [3:0] dat[5] = '{4'hA, 4'hB, 4'hB, 4'hC, 4'hD};
    logic r1r[5]   = '{1, 0, 1, 1, 1};
    logic [2:0] ex[5] = '{3'b101, 3'b010, 3'b011, 3'b011, 3'b101};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0_val = (ids[i] == 0); req1_val = (ids[i] == 1); memreq_rdy = 1;
      @(negedge clk);
      checks++;
      if ({req0_rdy, req1_rdy} !== ((ids[i] == 0) ? 2'b10 : 2'b01) || dut_out() !== m_out()) begin
        $display("FAIL il_issue[%0d] got=%b exp_id=%0d", i, {req0_rdy, req1_rdy}, ids[i]); errors++;
      end
      m_tick();
      @(posedge clk); #1;
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      memresp_val = 1; memresp_msg = RSW'(dat[i]); resp0_rdy = 1; resp1_rdy = r1r[i];
      @(negedge clk);
      checks++;
      if ({resp0_val, resp1_val, memresp_rdy} !== ex[i] || dut_out() !== m_out()) begin
        $display("FAIL il_resp[%0d] got=%b exp=%b", i, {resp0_val, resp1_val, memresp_rdy}, ex[i]); errors++;
      end
      checks++;
      if ((ex[i][2] ? resp0_msg : resp1_msg) !== RSW'(dat[i])) begin
        $display("FAIL il_data[%0d] got=%h/%h exp=%h", i, resp0_msg, resp1_msg, dat[i]); errors++;
      end
      m_tick();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0_val = 1; memreq_rdy = 1;
      @(negedge clk); m_tick();
      @(posedge clk); #1;
    end
    req0_val = 1; req1_val = 1; memreq_rdy = 1; memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
    reset = 1; m_clear();
    #1;
    checks++;
    if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
      $display("FAIL mid_reset got=%b exp=000000",
               {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy}); errors++;
    end
    @(posedge clk); #1;
    reset = 0; memresp_val = 0;
    @(negedge clk);
    checks++;
    if ({req0_rdy, req1_rdy, memresp_rdy} !== 3'b100 || dut_out() !== m_out()) begin
      $display("FAIL post_reset_tie got=%b exp=100", {req0_rdy, req1_rdy, memresp_rdy}); errors++;
    end
    m_tick();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        reset = 1; m_clear();
      end else begin
        reset = 0;
      end
      req0_val = $urandom_range(1); req1_val = $urandom_range(1);
      memreq_rdy = ($urandom_range(3) != 0);
      resp0_rdy = $urandom_range(1); resp1_rdy = $urandom_range(1);
      memresp_val = (m_q.size() > 0) && !reset && $urandom_range(1);
      req0_msg = RQW'({$urandom(), $urandom(), $urandom()});
      req1_msg = RQW'({$urandom(), $urandom(), $urandom()});
      memresp_msg = RSW'({$urandom(), $urandom()});
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out()) begin
        $display("FAIL rand_vec[%0d] got=%h exp=%h", i, dut_out(), m_out()); errors++;
      end
      m_tick();
      @(posedge clk); #1;
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1; m_clear();
    #1;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb_2to1_4b.md
MEM_ARB_2TO1_4B -- requirements
Module: mem_arb_2to1_4b

Interface
REQ-001 SHALL have parameter p_max_inflight, default 4, maximum outstanding downstream requests (power of 2, ≥2).
REQ-002 SHALL have parameters p_opaque_nbits 8, p_addr_nbits 32, p_data_nbits 32, sizing mem_req_4B_t / mem_resp_4B_t (c_req_nbits, c_resp_nbits).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_val / req0_rdy / req0_msg  in/out/in  1/1/c_req_nbits  requester 0 request
- req1_val / req1_rdy / req1_msg  in/out/in  1/1/c_req_nbits  requester 1 request
- resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/c_resp_nbits  requester 0 response
- resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/c_resp_nbits  requester 1 response
- memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/c_req_nbits  shared memory port request
- memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/c_resp_nbits  shared memory port response

Function
REQ-004 SHALL fire a transfer on any interface only in a cycle with val && rdy high.
REQ-005 SHALL drive memreq_val = (req0_val | req1_val) && !id_full && !reset; memreq_val SHALL NOT depend on memreq_rdy.
REQ-006 SHALL select a grant: locked grant if lock set; else only valid requester; else round-robin, the requester not in last_grant.
REQ-007 SHALL pass memreq_msg = granted requester's msg unmodified; reqN_rdy = (grant==N) && memreq_rdy && !id_full; non-granted rdy = 0.
REQ-008 SHALL set lock when memreq_val && !memreq_rdy and clear it on memreq fire, holding grant and message stable while stalled.
REQ-009 SHALL update last_grant to the granted index on every memreq fire only.
REQ-010 SHALL push the granted index into an in-order ID FIFO (depth p_max_inflight) on memreq fire; pop on memresp fire.
REQ-011 SHALL compute id_full from the pre-pop count; a same-cycle pop does not free a push slot (no bypass).
REQ-012 SHALL drive respN_val = memresp_val && !id_empty && (head==N); respN_msg = memresp_msg; memresp_rdy = !id_empty && resp[head]_rdy.
REQ-013 SHALL hold memresp_rdy = 0 while id_empty; a memresp_val arriving then is a protocol error, held (not dropped) and flagged by a simulation-only assertion.
REQ-014 SHALL allow simultaneous push and pop when not full; count unchanged; pointers wrap modulo p_max_inflight.
REQ-015 SHALL give zero-cycle combinational forwarding in both directions; no added latency.

Reset
REQ-016 SHALL, while reset high, force memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy to 0.
REQ-017 SHALL on reset asynchronously clear FIFO pointers and count to 0, lock to 0, last_grant to 1 (requester 0 wins first tie).
REQ-018 SHALL discard in-flight IDs on reset mid-operation; late responses after reset are covered by REQ-013.

Configuration
REQ-019 SHALL, with MEM_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority (requester 0 always wins unlocked ties); last_grant still updates but is unused.
REQ-020 SHALL, without MEM_ARB_FIXED_PRIO_EN, use round-robin per REQ-006; lock behaviour is identical in both builds.

Verification
REQ-021 Both requesters valid 6 cycles, memreq_rdy=1 -> grants 0,1,0,1,0,1; round-robin build only.
REQ-022 Same stimulus, MEM_ARB_FIXED_PRIO_EN -> six grants to 0, req1_rdy stays 0.
REQ-023 req1 valid, memreq_rdy=0 for 3 cycles, req0 asserts in cycle 2 -> grant stays 1, memreq_msg stable, req1 fires cycle 4.
REQ-024 5 requests issued, memresp_rdy path blocked, p_max_inflight=4 -> 4 fire, memreq_val drops; one response pops -> 5th fires next cycle, not same cycle.
REQ-025 Interleaved issue 0,1,1,0 then in-order responses data 0xA,0xB,0xC,0xD -> resp0 gets A,D; resp1 gets B,C; resp1_rdy=0 stalls memresp_rdy.
REQ-026 reset asserted with 3 outstanding -> all outputs 0 immediately, count 0; first post-reset tie granted to requester 0.
